// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - writeback arbiter and register scoreboard for a 1W integer register file
//
// Two writeback producers share the single register file write port.
// s0 is the ALU pipe and s1 is the load/store unit. Each producer has a
// one-entry holding slot. A round-robin arbiter drains one slot per cycle.
// A pending-write scoreboard stalls issue on RAW and WAW hazards.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, the register being committed this cycle is forwarded to
//   the issuing instruction's sources. The RAW stall for those sources is
//   then masked.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   s0_valid/s0_ready/s0_rdc/s0_rd ALU writeback request (valid/ready)
//   s1_valid/s1_ready/s1_rdc/s1_rd LSU writeback request (valid/ready)
//   RF_W, rdc, rd                  register file write enable/address/data
//   iss_valid, iss_rs1c, iss_rs2c, iss_rdc  issuing instruction operands
//   iss_stall                      hazard stall back to decode
//   pend                           outstanding-write bit per register
//   fwd1_hit/fwd1_data, fwd2_hit/fwd2_data  (WB_BYPASS_EN only) commit forwarding
module regfile_wb_sched #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [4:0]      s0_rdc,
    input  logic [XLEN-1:0] s0_rd,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [4:0]      s1_rdc,
    input  logic [XLEN-1:0] s1_rd,
    output logic            RF_W,
    output logic [4:0]      rdc,
    output logic [XLEN-1:0] rd,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rs1c,
    input  logic [4:0]      iss_rs2c,
    input  logic [4:0]      iss_rdc,
    output logic            iss_stall,
`ifdef WB_BYPASS_EN
    output logic            fwd1_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd2_data,
`endif
    output logic [NREG-1:0] pend
);

    logic            r_h0_v;
    logic [4:0]      r_h0_rdc;
    logic [XLEN-1:0] r_h0_data;
    logic            r_h1_v;
    logic [4:0]      r_h1_rdc;
    logic [XLEN-1:0] r_h1_data;
    // 1 = s1 was granted last, so s0 wins the next tie.
    logic            r_last_s1;
    logic [NREG-1:0] r_pend;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_gnt_any;
    logic            w_haz1;
    logic            w_haz2;
    logic            w_hazd;
    logic            w_issue;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;

    assign w_gnt0    = r_h0_v & (!r_h1_v | r_last_s1);
    assign w_gnt1    = r_h1_v & (!r_h0_v | !r_last_s1);
    assign w_gnt_any = w_gnt0 | w_gnt1;

    // A slot that is being drained this cycle may be refilled at the same edge.
    assign s0_ready = !r_h0_v | w_gnt0;
    assign s1_ready = !r_h1_v | w_gnt1;

    always_comb begin
        rdc  = 5'd0;
        rd   = '0;
        RF_W = 1'b0;
        if (w_gnt0) begin
            rdc = r_h0_rdc;
            rd  = r_h0_data;
        end else if (w_gnt1) begin
            rdc = r_h1_rdc;
            rd  = r_h1_data;
        end
        // A grant to x0 still drains the slot but never writes the file.
        RF_W = w_gnt_any & (rdc != 5'd0);
    end

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = RF_W & (rdc == iss_rs1c) & (rdc != 5'd0);
    assign fwd2_hit  = RF_W & (rdc == iss_rs2c) & (rdc != 5'd0);
    assign fwd1_data = rd;
    assign fwd2_data = rd;
    assign w_haz1    = (iss_rs1c != 5'd0) & r_pend[iss_rs1c] & !fwd1_hit;
    assign w_haz2    = (iss_rs2c != 5'd0) & r_pend[iss_rs2c] & !fwd2_hit;
`else
    assign w_haz1    = (iss_rs1c != 5'd0) & r_pend[iss_rs1c];
    assign w_haz2    = (iss_rs2c != 5'd0) & r_pend[iss_rs2c];
`endif
    // WAW is never masked: the destination must not be set twice.
    assign w_hazd    = (iss_rdc != 5'd0) & r_pend[iss_rdc];
    assign iss_stall = iss_valid & (w_haz1 | w_haz2 | w_hazd);

    assign w_issue   = iss_valid & !iss_stall & (iss_rdc != 5'd0);
    assign w_set_vec = w_issue ? (NREG'(1) << iss_rdc) : '0;
    assign w_clr_vec = (w_gnt_any & (rdc != 5'd0)) ? (NREG'(1) << rdc) : '0;
    assign pend      = r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h0_v    <= 1'b0;
            r_h0_rdc  <= 5'd0;
            r_h0_data <= '0;
            r_h1_v    <= 1'b0;
            r_h1_rdc  <= 5'd0;
            r_h1_data <= '0;
            r_last_s1 <= 1'b1;
            r_pend    <= '0;
        end else begin
            if (s0_valid && s0_ready) begin
                r_h0_v    <= 1'b1;
                r_h0_rdc  <= s0_rdc;
                r_h0_data <= s0_rd;
            end else if (w_gnt0) begin
                r_h0_v    <= 1'b0;
            end
            if (s1_valid && s1_ready) begin
                r_h1_v    <= 1'b1;
                r_h1_rdc  <= s1_rdc;
                r_h1_data <= s1_rd;
            end else if (w_gnt1) begin
                r_h1_v    <= 1'b0;
            end
            if (w_gnt0) begin
                r_last_s1 <= 1'b0;
            end else if (w_gnt1) begin
                r_last_s1 <= 1'b1;
            end
            // Set is applied after clear so a same-bit collision leaves it set.
            r_pend <= (r_pend & ~w_clr_vec) | w_set_vec;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - scoreboard bench for regfile_wb_sched
module tb_regfile_wb_sched;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s0_valid = 1'b0;
    logic            s0_ready;
    logic [4:0]      s0_rdc = '0;
    logic [XLEN-1:0] s0_rd = '0;
    logic            s1_valid = 1'b0;
    logic            s1_ready;
    logic [4:0]      s1_rdc = '0;
    logic [XLEN-1:0] s1_rd = '0;
    logic            RF_W;
    logic [4:0]      rdc;
    logic [XLEN-1:0] rd;
    logic            iss_valid = 1'b0;
    logic [4:0]      iss_rs1c = '0;
    logic [4:0]      iss_rs2c = '0;
    logic [4:0]      iss_rdc = '0;
    logic            iss_stall;
    logic [31:0]     pend;
`ifdef WB_BYPASS_EN
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
`endif

    regfile_wb_sched #(.XLEN(XLEN), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rdc(s0_rdc), .s0_rd(s0_rd),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rdc(s1_rdc), .s1_rd(s1_rd),
        .RF_W(RF_W), .rdc(rdc), .rd(rd),
        .iss_valid(iss_valid), .iss_rs1c(iss_rs1c), .iss_rs2c(iss_rs2c), .iss_rdc(iss_rdc),
        .iss_stall(iss_stall),
`ifdef WB_BYPASS_EN
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
`endif
        .pend(pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } wb_t;

    wb_t             exp_q[$];
    wb_t             mon_e;
    int              n_err = 0;
    int              n_checks = 0;
    logic [XLEN-1:0] rf [32];

    // Register file model written by the DUT's write port.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (RF_W) begin
            rf[rdc] <= rd;
        end
    end

    // Commit monitor: every write must match the next expected writeback.
    always @(negedge clk) begin
        if (!rst && RF_W) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL commit_unexpected: got x%0d=%h, required no commit", rdc, rd);
            end else begin
                mon_e = exp_q.pop_front();
                if (rdc !== mon_e.a || rd !== mon_e.d) begin
                    n_err++;
                    $display("FAIL commit_order: got x%0d=%h, required x%0d=%h", rdc, rd, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic clear_inputs();
        s0_valid = 1'b0; s0_rdc = '0; s0_rd = '0;
        s1_valid = 1'b0; s1_rdc = '0; s1_rd = '0;
        iss_valid = 1'b0; iss_rs1c = '0; iss_rs2c = '0; iss_rdc = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #3;
        n_checks++;
        if (RF_W !== 1'b0 || rdc !== 5'd0 || rd !== 64'd0) begin
            n_err++;
            $display("FAIL reset_port: got RF_W=%b rdc=%0d rd=%h, required 0 0 0", RF_W, rdc, rd);
        end
        n_checks++;
        if (pend !== 32'd0) begin
            n_err++;
            $display("FAIL reset_pend: got %h, required 0", pend);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1 || iss_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got s0=%b s1=%b stall=%b, required 1 1 0", s0_ready, s1_ready, iss_stall);
        end
    endtask

    task automatic test_single();
        do_reset();
        s0_valid = 1'b1; s0_rdc = 5'd5; s0_rd = 64'h1234;
        exp_q.push_back('{a: 5'd5, d: 64'h1234});
        n_checks++;
        if (s0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: got %b, required 1", s0_ready);
        end
        @(posedge clk); #1;
        s0_valid = 1'b0;
        n_checks++;
        if (RF_W !== 1'b1 || rdc !== 5'd5 || rd !== 64'h1234) begin
            n_err++;
            $display("FAIL single_port: got RF_W=%b rdc=%0d rd=%h, required 1 5 1234", RF_W, rdc, rd);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rf[5] !== 64'h1234 || RF_W !== 1'b0) begin
            n_err++;
            $display("FAIL single_rf: got x5=%h RF_W=%b, required 1234 0", rf[5], RF_W);
        end
    endtask

    task automatic tie(input logic [4:0] a0, input logic [XLEN-1:0] d0,
                       input logic [4:0] a1, input logic [XLEN-1:0] d1,
                       input bit s0_first, input string name);
        s0_valid = 1'b1; s0_rdc = a0; s0_rd = d0;
        s1_valid = 1'b1; s1_rdc = a1; s1_rd = d1;
        if (s0_first) begin
            exp_q.push_back('{a: a0, d: d0});
            exp_q.push_back('{a: a1, d: d1});
        end else begin
            exp_q.push_back('{a: a1, d: d1});
            exp_q.push_back('{a: a0, d: d0});
        end
        @(posedge clk); #1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        n_checks++;
        if (rdc !== (s0_first ? a0 : a1)) begin
            n_err++;
            $display("FAIL %s_first: got x%0d, required x%0d", name, rdc, s0_first ? a0 : a1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rdc !== (s0_first ? a1 : a0)) begin
            n_err++;
            $display("FAIL %s_second: got x%0d, required x%0d", name, rdc, s0_first ? a1 : a0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        do_reset();
        tie(5'd3, 64'hA, 5'd4, 64'hB, 1'b1, "tie1");
        tie(5'd10, 64'h10, 5'd11, 64'h11, 1'b1, "tie2");
    endtask

    task automatic test_x0();
        do_reset();
        s1_valid = 1'b1; s1_rdc = 5'd0; s1_rd = 64'hFFFF;
        @(posedge clk); #1;
        s1_valid = 1'b0;
        n_checks++;
        if (RF_W !== 1'b0 || rdc !== 5'd0 || rd !== 64'hFFFF) begin
            n_err++;
            $display("FAIL x0_drain: got RF_W=%b rdc=%0d rd=%h, required 0 0 ffff", RF_W, rdc, rd);
        end
        @(posedge clk); #1;
        n_checks++;
        if (s1_ready !== 1'b1 || rf[0] !== 64'd0) begin
            n_err++;
            $display("FAIL x0_empty: got s1_ready=%b x0=%h, required 1 0", s1_ready, rf[0]);
        end
        // An x0 grant from s0 moves the pointer, so s1 wins the following tie.
        s0_valid = 1'b1; s0_rdc = 5'd0; s0_rd = 64'h5;
        @(posedge clk); #1;
        s0_valid = 1'b0;
        @(posedge clk); #1;
        tie(5'd20, 64'h20, 5'd21, 64'h21, 1'b0, "x0_ptr");
    endtask

    task automatic test_back_to_back();
        int idx0 = 0;
        int idx1 = 0;
        int nw = 0;
        bit acc0;
        bit acc1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{a: 5'd12, d: 64'h100 + 64'(k)});
            exp_q.push_back('{a: 5'd13, d: 64'h200 + 64'(k)});
        end
        s0_valid = 1'b1; s0_rdc = 5'd12; s0_rd = 64'h100;
        s1_valid = 1'b1; s1_rdc = 5'd13; s1_rd = 64'h200;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc0 = s0_valid & s0_ready;
            acc1 = s1_valid & s1_ready;
            if (RF_W) nw++;
            @(posedge clk); #1;
            if (acc0) idx0++;
            if (acc1) idx1++;
            s0_valid = (idx0 < 4); s0_rd = 64'h100 + 64'(idx0);
            s1_valid = (idx1 < 4); s1_rd = 64'h200 + 64'(idx1);
            if (c == 8) begin
                n_checks++;
                if (nw !== 8) begin
                    n_err++;
                    $display("FAIL b2b_throughput: got %0d writes in 9 cycles, required 8", nw);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_raw();
        do_reset();
        iss_valid = 1'b1; iss_rdc = 5'd7;
        n_checks++;
        if (iss_stall !== 1'b0) begin
            n_err++;
            $display("FAIL raw_issue: got stall=%b, required 0", iss_stall);
        end
        @(posedge clk); #1;
        iss_rdc = 5'd0; iss_rs1c = 5'd7;
        n_checks++;
        if (pend !== 32'h80 || iss_stall !== 1'b1) begin
            n_err++;
            $display("FAIL raw_stall: got pend=%h stall=%b, required 80 1", pend, iss_stall);
        end
        s0_valid = 1'b1; s0_rdc = 5'd7; s0_rd = 64'h77;
        exp_q.push_back('{a: 5'd7, d: 64'h77});
        @(posedge clk); #1;
        s0_valid = 1'b0;
`ifdef WB_BYPASS_EN
        n_checks++;
        if (iss_stall !== 1'b0 || fwd1_hit !== 1'b1 || fwd1_data !== 64'h77) begin
            n_err++;
            $display("FAIL raw_bypass: got stall=%b hit=%b data=%h, required 0 1 77", iss_stall, fwd1_hit, fwd1_data);
        end
`else
        n_checks++;
        if (iss_stall !== 1'b1) begin
            n_err++;
            $display("FAIL raw_commit_cycle: got stall=%b, required 1", iss_stall);
        end
`endif
        @(posedge clk); #1;
        n_checks++;
        if (pend !== 32'h0 || iss_stall !== 1'b0) begin
            n_err++;
            $display("FAIL raw_release: got pend=%h stall=%b, required 0 0", pend, iss_stall);
        end
        clear_inputs();
    endtask

    task automatic test_waw();
        do_reset();
        iss_valid = 1'b1; iss_rdc = 5'd9;
        @(posedge clk); #1;
        n_checks++;
        if (pend !== 32'h200 || iss_stall !== 1'b1) begin
            n_err++;
            $display("FAIL waw_stall: got pend=%h stall=%b, required 200 1", pend, iss_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (pend !== 32'h200 || iss_stall !== 1'b1) begin
            n_err++;
            $display("FAIL waw_hold: got pend=%h stall=%b, required 200 1", pend, iss_stall);
        end
        s1_valid = 1'b1; s1_rdc = 5'd9; s1_rd = 64'h99;
        exp_q.push_back('{a: 5'd9, d: 64'h99});
        @(posedge clk); #1;
        s1_valid = 1'b0;
        n_checks++;
        if (iss_stall !== 1'b1) begin
            n_err++;
            $display("FAIL waw_commit_cycle: got stall=%b, required 1", iss_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (pend !== 32'h0 || iss_stall !== 1'b0) begin
            n_err++;
            $display("FAIL waw_clear: got pend=%h stall=%b, required 0 0", pend, iss_stall);
        end
        @(posedge clk); #1;
        iss_valid = 1'b0;
        n_checks++;
        if (pend !== 32'h200) begin
            n_err++;
            $display("FAIL waw_reissue: got pend=%h, required 200", pend);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        iss_valid = 1'b1; iss_rdc = 5'd7;
        @(posedge clk); #1;
        iss_rdc = 5'd9;
        s0_valid = 1'b1; s0_rdc = 5'd7; s0_rd = 64'hDEAD;
        s1_valid = 1'b1; s1_rdc = 5'd9; s1_rd = 64'hBEEF;
        @(posedge clk); #1;
        clear_inputs();
        n_checks++;
        if (pend !== 32'h280 || RF_W !== 1'b1 || s1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_full: got pend=%h RF_W=%b s1_ready=%b, required 280 1 0", pend, RF_W, s1_ready);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (RF_W !== 1'b0 || pend !== 32'h0 || rdc !== 5'd0 || rd !== 64'd0) begin
            n_err++;
            $display("FAIL rmid_async: got RF_W=%b pend=%h rdc=%0d rd=%h, required 0 0 0 0", RF_W, pend, rdc, rd);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_ready: got s0=%b s1=%b, required 1 1", s0_ready, s1_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (RF_W !== 1'b0) begin
                n_err++;
                $display("FAIL rmid_stale: got RF_W=%b rdc=%0d, required 0", RF_W, rdc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_x0();
        test_back_to_back();
        test_raw();
        test_waw();
        test_reset_mid();
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
